// File: rtl/ser_nt1_mux_ctrl.sv
// N:1 serializer front end: word FIFO on a valid/ready input, one OUT_W slice per clk out,
// with PRBS7 / fixed-pattern test modes and a one-shot underflow pulse on DATA starvation.
module ser_nt1_mux_ctrl #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [IN_W-1:0]                   in_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [1:0]                        mode_i,
    input  logic                              msb_first_i,
    input  logic [IN_W-1:0]                   pat_i,
    output logic [OUT_W-1:0]                  out_data_o,
    output logic                              out_valid_o,
    output logic                              underflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
    output logic [1:0]                        active_mode_o
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = $clog2(RATIO);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0]    DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_DATA = 2'd1, M_PRBS = 2'd2, M_PAT = 2'd3} mode_t;

    // Handshake: a word transfers on a rising clk edge where in_valid_i && in_ready_o;
    // in_ready_o depends only on rst_i and the FIFO level, never on in_valid_i.
    logic [IN_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push, pop;

    mode_t            act_mode_q, req_mode;
    logic [IN_W-1:0]  shift_q;
    logic             msb_q, busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       prbs_q, prbs_d;
    logic [OUT_W-1:0] prbs_bits;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q, underflow_q;

    logic             boundary;
    logic [IN_W-1:0]  src_word, rest_word;
    logic             src_msb;
    logic [OUT_W-1:0] slice;

    assign req_mode   = mode_t'(mode_i);
    assign boundary   = !busy_q || (cnt_q == LAST_CNT);
    assign in_ready_o = !rst_i && (level_q < DEPTH_L);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = !rst_i && boundary && (req_mode == M_DATA) && (level_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // At a boundary the next word (FIFO head or pat) is sliced directly; otherwise the shifter.
    always_comb begin
        src_word = shift_q;
        src_msb  = msb_q;
        if (boundary) begin
            src_word = (req_mode == M_PAT) ? pat_i : mem_q[rd_ptr_q];
            src_msb  = msb_first_i;
        end
        slice     = src_msb ? src_word[IN_W-1 -: OUT_W] : src_word[OUT_W-1:0];
        rest_word = src_msb ? (src_word << OUT_W) : (src_word >> OUT_W);
    end

    // PRBS7 (x^7+x^6+1) stepped OUT_W times; the first bit generated lands in the MSB.
    always_comb begin
        logic [6:0] s;
        logic       nb;
        prbs_bits = '0;
        s = (boundary && req_mode == M_PRBS && act_mode_q != M_PRBS) ? 7'h7F : prbs_q;
        for (int i = 0; i < OUT_W; i++) begin
            nb = s[6] ^ s[5];
            prbs_bits[OUT_W-1-i] = nb;
            s = {s[5:0], nb};
        end
        prbs_d = s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_mode_q  <= M_IDLE;
            shift_q     <= '0;
            msb_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            prbs_q      <= 7'h7F;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            if (boundary) begin
                act_mode_q <= req_mode;
                case (req_mode)
                    M_IDLE: begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                    M_DATA: begin
                        if (level_q != '0) begin
                            out_data_q  <= slice;
                            out_valid_q <= 1'b1;
                            shift_q     <= rest_word;
                            msb_q       <= msb_first_i;
                            cnt_q       <= '0;
                            busy_q      <= 1'b1;
                        end else begin
                            // Starved: pulse only on the valid->invalid transition.
                            out_data_q  <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            underflow_q <= out_valid_q;
                        end
                    end
                    M_PRBS: begin
                        out_data_q  <= prbs_bits;
                        out_valid_q <= 1'b1;
                        prbs_q      <= prbs_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                    end
                    M_PAT: begin
                        out_data_q  <= slice;
                        out_valid_q <= 1'b1;
                        shift_q     <= rest_word;
                        msb_q       <= msb_first_i;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (act_mode_q == M_PRBS) begin
                    out_data_q <= prbs_bits;
                    prbs_q     <= prbs_d;
                end else begin
                    out_data_q <= slice;
                    shift_q    <= rest_word;
                end
            end
        end
    end

    assign out_data_o    = out_data_q;
    assign out_valid_o   = out_valid_q;
    assign underflow_o   = underflow_q;
    assign fifo_level_o  = level_q;
    assign active_mode_o = act_mode_q;
endmodule

// File: tb/tb_ser_nt1_mux_ctrl.sv
// Bench for ser_nt1_mux_ctrl: scenario tasks with a slice scoreboard (exp_q) and inline checks.
module tb_ser_nt1_mux_ctrl;
    localparam int IN_W       = 16;
    localparam int OUT_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int RATIO      = IN_W / OUT_W;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic             msb_first;
    logic [IN_W-1:0]  pat;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             underflow;
    logic [LW-1:0]    fifo_level;
    logic [1:0]       active_mode;

    logic [OUT_W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ser_nt1_mux_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .mode_i(mode), .msb_first_i(msb_first), .pat_i(pat),
        .out_data_o(out_data), .out_valid_o(out_valid), .underflow_o(underflow),
        .fifo_level_o(fifo_level), .active_mode_o(active_mode)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w, input logic msb, input int idx);
        logic [IN_W-1:0] t;
        if (msb) t = w >> (IN_W - OUT_W * (idx + 1));
        else     t = w >> (OUT_W * idx);
        return t[OUT_W-1:0];
    endfunction

    task automatic push_exp(input logic [IN_W-1:0] w, input logic msb);
        for (int i = 0; i < RATIO; i++) exp_q.push_back(slice_of(w, msb, i));
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0; msb_first = 1'b1; pat = '0;
        tick; tick;
        n_total++;
        if ({out_valid, underflow, out_data} !== '0)
            $display("FAIL reset_outputs: got v=%0b u=%0b d=%0h want all 0", out_valid, underflow, out_data);
        else n_pass++;
        n_total++;
        if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b want 1", in_ready); else n_pass++;
        tick;
    endtask

    task automatic test_single(input logic msb);
        logic [OUT_W-1:0] e;
        exp_q.delete();
        mode = 2'd1; msb_first = msb; in_data = 16'hA5C3; in_valid = 1'b1;
        push_exp(16'hA5C3, msb);
        tick;
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, fifo_level} !== {1'b0, LW'(1)})
            $display("FAIL single_push_edge: got v=%0b lvl=%0d want v=0 lvl=1", out_valid, fifo_level);
        else n_pass++;
        for (int i = 0; i < RATIO; i++) begin
            tick;
            e = exp_q.pop_front();
            n_total++;
            if ({out_valid, underflow, out_data} !== {1'b1, 1'b0, e})
                $display("FAIL single_slice%0d msb=%0b: got v=%0b u=%0b d=%0h want v=1 u=0 d=%0h",
                         i, msb, out_valid, underflow, out_data, e);
            else n_pass++;
        end
        tick;
        n_total++;
        if ({out_valid, underflow, out_data} !== {1'b0, 1'b1, 4'h0})
            $display("FAIL single_underflow: got v=%0b u=%0b d=%0h want v=0 u=1 d=0", out_valid, underflow, out_data);
        else n_pass++;
        tick;
        n_total++;
        if (underflow !== 1'b0) $display("FAIL single_no_repeat_uf: got %0b want 0", underflow); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [IN_W-1:0]  w;
        logic [OUT_W-1:0] e;
        logic             ev, eu;
        exp_q.delete();
        mode = 2'd1; msb_first = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 3) begin
                w = IN_W'($urandom_range(0, 16'hFFFF));
                in_data = w; in_valid = 1'b1;
                push_exp(w, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            tick;
            ev = (c >= 1 && c <= 12);
            eu = (c == 13);
            e  = '0;
            if (ev) begin
                if (exp_q.size() == 0) e = 'x;
                else e = exp_q.pop_front();
            end
            n_total++;
            if ({out_valid, underflow, out_data} !== {ev, eu, e})
                $display("FAIL b2b_cycle%0d: got v=%0b u=%0b d=%0h want v=%0b u=%0b d=%0h",
                         c, out_valid, underflow, out_data, ev, eu, e);
            else n_pass++;
        end
    endtask

    task automatic test_idle_fill;
        logic [IN_W-1:0]  w;
        logic [OUT_W-1:0] e;
        exp_q.delete();
        mode = 2'd0; msb_first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = IN_W'($urandom_range(0, 16'hFFFF));
            in_data = w; in_valid = 1'b1;
            n_total++;
            if (in_ready !== (i < FIFO_DEPTH))
                $display("FAIL fill_ready%0d: got %0b want %0b", i, in_ready, (i < FIFO_DEPTH));
            else n_pass++;
            if (i < FIFO_DEPTH) push_exp(w, 1'b0);
            tick;
        end
        in_valid = 1'b0;
        n_total++;
        if ({fifo_level, in_ready, out_valid} !== {LW'(FIFO_DEPTH), 1'b0, 1'b0})
            $display("FAIL fill_full: got lvl=%0d rdy=%0b v=%0b want lvl=%0d rdy=0 v=0",
                     fifo_level, in_ready, out_valid, FIFO_DEPTH);
        else n_pass++;
        mode = 2'd1;
        for (int c = 0; c < FIFO_DEPTH * RATIO; c++) begin
            tick;
            if (c == 0) begin
                n_total++;
                if (fifo_level !== LW'(FIFO_DEPTH - 1))
                    $display("FAIL drain_level_first: got %0d want %0d", fifo_level, FIFO_DEPTH - 1);
                else n_pass++;
            end
            e = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
            n_total++;
            if ({out_valid, out_data} !== {1'b1, e})
                $display("FAIL drain_slice%0d: got v=%0b d=%0h want v=1 d=%0h", c, out_valid, out_data, e);
            else n_pass++;
        end
        tick;
        n_total++;
        if ({fifo_level, out_valid, underflow} !== {LW'(0), 1'b0, 1'b1})
            $display("FAIL drain_end: got lvl=%0d v=%0b u=%0b want lvl=0 v=0 u=1", fifo_level, out_valid, underflow);
        else n_pass++;
    endtask

    task automatic test_prbs;
        logic             pb [0:1030];
        logic [OUT_W-1:0] e;
        int               n_bad;
        for (int i = 0; i < 7; i++) pb[i] = 1'b1;
        for (int i = 7; i <= 1030; i++) pb[i] = pb[i-7] ^ pb[i-6];
        mode = 2'd2;
        n_bad = 0;
        for (int c = 0; c < 254; c++) begin
            tick;
            for (int b = 0; b < OUT_W; b++) e[OUT_W-1-b] = pb[7 + OUT_W * c + b];
            n_total++;
            if ({out_valid, out_data} !== {1'b1, e}) begin
                $display("FAIL prbs_slice%0d: got v=%0b d=%0h want v=1 d=%0h", c, out_valid, out_data, e);
                n_bad++;
            end else n_pass++;
        end
        mode = 2'd0;
        for (int c = 0; c < 8; c++) begin
            if (!out_valid) break;
            tick;
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL prbs_exit: got v=%0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_pat_switch;
        logic [OUT_W-1:0] e;
        exp_q.delete();
        mode = 2'd1; msb_first = 1'b1; in_data = 16'hA5C3; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            e = slice_of(16'hA5C3, 1'b1, i);
            n_total++;
            if ({out_valid, out_data} !== {1'b1, e})
                $display("FAIL pat_pre_slice%0d: got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, e);
            else n_pass++;
        end
        mode = 2'd3; pat = 16'h1234;
        exp_q.push_back(slice_of(16'hA5C3, 1'b1, 2));
        exp_q.push_back(slice_of(16'hA5C3, 1'b1, 3));
        for (int k = 0; k < 3; k++) push_exp(16'h1234, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c == 2) begin
                in_data = IN_W'($urandom_range(0, 16'hFFFF)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            e = exp_q.pop_front();
            n_total++;
            if ({out_valid, out_data} !== {1'b1, e})
                $display("FAIL pat_slice%0d: got v=%0b d=%0h want v=1 d=%0h", c, out_valid, out_data, e);
            else n_pass++;
        end
        n_total++;
        if (fifo_level !== LW'(1)) $display("FAIL pat_no_pop: got lvl=%0d want 1", fifo_level); else n_pass++;
        rst = 1'b1;
        tick;
        n_total++;
        if ({out_valid, out_data, underflow, fifo_level, in_ready} !== '0)
            $display("FAIL midword_reset: got v=%0b d=%0h u=%0b lvl=%0d rdy=%0b want all 0",
                     out_valid, out_data, underflow, fifo_level, in_ready);
        else n_pass++;
        rst = 1'b0; mode = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_total++;
            if ({out_valid, underflow, out_data} !== '0)
                $display("FAIL post_reset_idle%0d: got v=%0b u=%0b d=%0h want all 0", c, out_valid, underflow, out_data);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single(1'b1);
        test_single(1'b0);
        test_back_to_back();
        test_idle_fill();
        test_prbs();
        test_pat_switch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
